mem_port_arbiter: RTL

Shares one single-port, fixed-latency unified memory between the instruction-fetch stage (read-only) and the MEM stage (LW read / SW write) of the 5-stage pipeline. Grants one access at a time and sequences the memory handshake. Returns read data and ack pulses to each requester, and drives per-stage stall signals that freeze the pipeline while an access is pending. Data accesses win ties, with a starvation guard for fetch; a fetch that is squashed by a branch or jump is flushed.

---
 rtl/mem_port_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency single-port memory between fetch and data requesters.
// Latency: grant -> mem_en next cycle -> ack MEM_LAT cycles later; one access per MEM_LAT+1 cycles.
// Backpressure: requesters hold req until ack; if_stall/mem_stall freeze their stages meanwhile.
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    input  logic          i_flush,
    output logic          i_ack,
    output logic [31:0]   i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    output logic          d_ack,
    output logic [31:0]   d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-3:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic          if_stall,
    output logic          mem_stall,
    output logic          busy
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    localparam logic [3:0] LP_LAT  = 4'(MEM_LAT);
    localparam logic [3:0] LP_SMAX = 4'(STARVE_MAX);

    state_t        r_state;
    logic [3:0]    r_cnt;
    logic [3:0]    r_starve;
    logic          r_own_i;
    logic          r_flushed;
    logic          r_mem_en;
    logic          r_mem_we;
    logic [AW-3:0] r_mem_addr;
    logic [31:0]   r_mem_wdata;

    logic w_resp;
    logic w_arb;
    logic w_i_elig;
    logic w_d_elig;
    logic w_gnt_i;
    logic w_gnt_d;
    logic w_unused_lsbs;

    assign w_unused_lsbs = ^{i_addr[1:0], d_addr[1:0]};

    assign w_resp  = (r_state == S_WAIT) && (r_cnt == 4'd1);
    assign i_ack   = w_resp & r_own_i & ~r_flushed & ~i_flush;
    assign d_ack   = w_resp & ~r_own_i;
    assign i_rdata = i_ack ? mem_rdata : 32'h0;
    assign d_rdata = d_ack ? mem_rdata : 32'h0;

    // The requester being acked this cycle sits out this arbitration round.
    assign w_arb    = (r_state == S_IDLE) | w_resp;
    assign w_i_elig = i_req & ~i_flush & ~i_ack;
    assign w_d_elig = d_req & ~d_ack;
    assign w_gnt_d  = w_arb & w_d_elig & ~(w_i_elig & (r_starve == LP_SMAX));
    assign w_gnt_i  = w_arb & w_i_elig & ~w_gnt_d;

    assign if_stall  = i_req & ~i_ack & ~i_flush;
    assign mem_stall = d_req & ~d_ack;
    assign busy      = (r_state != S_IDLE);
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_starve    <= 4'd0;
            r_own_i     <= 1'b0;
            r_flushed   <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 32'h0;
        end else begin
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;

            if (!i_req || w_gnt_i) begin
                r_starve <= 4'd0;
            end else if (w_gnt_d && (r_starve != LP_SMAX)) begin
                r_starve <= r_starve + 4'd1;
            end

            if (w_gnt_i || w_gnt_d) begin
                r_state    <= S_ISSUE;
                r_own_i    <= w_gnt_i;
                r_flushed  <= 1'b0;
                r_mem_en   <= 1'b1;
                r_mem_we   <= w_gnt_d & d_we;
                r_mem_addr <= w_gnt_i ? i_addr[AW-1:2] : d_addr[AW-1:2];
                if (w_gnt_d) begin
                    r_mem_wdata <= d_wdata;
                end
            end else begin
                case (r_state)
                    S_ISSUE: begin
                        r_state <= S_WAIT;
                        r_cnt   <= LP_LAT;
                    end
                    S_WAIT: begin
                        r_cnt <= r_cnt - 4'd1;
                        if (w_resp) begin
                            r_state <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
                // A squashed fetch still completes on the memory side; only its ack is dropped.
                if ((r_state != S_IDLE) && r_own_i && i_flush) begin
                    r_flushed <= 1'b1;
                end
            end
        end
    end

endmodule
